// File: rtl/btn_debounce_irq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ulx3s_btn_pkg
//  Purpose  : Shared constants for the button debounce / interrupt block:
//             default button count and reset levels, read FSM encoding and
//             snapshot bit layout.
//  Options  : BTN_AUTOREPEAT_EN (consumed by btn_debounce_irq and
//             btn_debounce_cell, not by this package)
//  Revision : 1.0 - initial release
// ============================================================================
package ulx3s_btn_pkg;

    localparam int C_BTN_BITS = 7;

    // btn[0] is active-low, so its idle level is 1.
    localparam logic [C_BTN_BITS-1:0] C_BTN_RESET_VALUE = 7'b0000001;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_SELECTED = 1'b1
    } read_state_t;

    // Snapshot layout: buttons in [n_btn-1:0], irq flag directly above them.
    function automatic int snap_irq_bit(input int n_btn);
        return n_btn;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce_irq_if.sv
`default_nettype none
// ============================================================================
//  Module   : btn_debounce_irq_if
//  Purpose  : Bundles the button inputs, ESP32 chip select and the debounced
//             status / snapshot outputs of btn_debounce_irq.
//  Signals  : btn_raw, csn        - asynchronous inputs (master drives)
//             btn_stable          - debounced button levels
//             btn_changed         - sticky per-button change mask
//             snapshot            - {irq, btn_stable}, frozen during a read
//             irq, read_done      - interrupt flag, read-complete pulse
//  Modports : master (stimulus / host side), slave (debouncer side)
//  Revision : 1.0 - initial release
// ============================================================================
interface btn_debounce_irq_if #(
    parameter int C_BTN_BITS = ulx3s_btn_pkg::C_BTN_BITS
);
    logic [C_BTN_BITS-1:0] btn_raw;
    logic                  csn;
    logic [C_BTN_BITS-1:0] btn_stable;
    logic [C_BTN_BITS-1:0] btn_changed;
    logic [C_BTN_BITS:0]   snapshot;
    logic                  irq;
    logic                  read_done;

    modport master (
        output btn_raw, csn,
        input  btn_stable, btn_changed, snapshot, irq, read_done
    );

    modport slave (
        input  btn_raw, csn,
        output btn_stable, btn_changed, snapshot, irq, read_done
    );
endinterface
`default_nettype wire

// File: rtl/btn_debounce_irq_cell.sv
`default_nettype none
// ============================================================================
//  Module   : btn_debounce_cell
//  Purpose  : One button: multi-flop synchroniser, debounce counter and stable
//             level flop. o_set pulses combinationally in the cycle whose
//             edge commits a new stable level (and, with auto-repeat, on each
//             repeat-counter wrap while pressed).
//  Ports    : clk, resetn (synchronous, active low), i_raw (async pin),
//             o_stable (debounced level), o_set (change event)
//  Options  : BTN_AUTOREPEAT_EN - adds a C_REPEAT_BITS repeat counter
//  Revision : 1.0 - initial release
// ============================================================================
module btn_debounce_cell #(
    parameter int   C_SYNC_STAGES   = 2,
    parameter int   C_DEBOUNCE_BITS = 16,
`ifdef BTN_AUTOREPEAT_EN
    parameter int   C_REPEAT_BITS   = 23,
    parameter logic C_PRESSED_LEVEL = 1'b1,
`endif
    parameter logic C_RESET_VALUE   = 1'b0
) (
    input  wire logic clk,
    input  wire logic resetn,
    input  wire logic i_raw,
    output logic      o_stable,
    output logic      o_set
);

    logic [C_SYNC_STAGES-1:0]   r_sync;
    logic [C_DEBOUNCE_BITS-1:0] r_cnt;
    logic                       r_stable;
    logic                       w_s;
    logic                       w_done;

    assign w_s    = r_sync[C_SYNC_STAGES-1];
    // Counter saturated with the input still disagreeing: commit this edge.
    assign w_done = (w_s != r_stable) && (r_cnt == '1);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_sync   <= {C_SYNC_STAGES{C_RESET_VALUE}};
            r_cnt    <= '0;
            r_stable <= C_RESET_VALUE;
        end else begin
            r_sync <= {r_sync[C_SYNC_STAGES-2:0], i_raw};
            if (w_s == r_stable) begin
                r_cnt <= '0;
            end else if (!w_done) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt    <= '0;
                r_stable <= w_s;
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    logic [C_REPEAT_BITS-1:0] r_rep;
    logic                     w_rep_wrap;

    assign w_rep_wrap = (r_stable == C_PRESSED_LEVEL) && (r_rep == '1);

    // Held at zero while released, so the first repeat lands a full period
    // after the debounced press.
    always_ff @(posedge clk) begin
        if (!resetn || (r_stable != C_PRESSED_LEVEL)) begin
            r_rep <= '0;
        end else begin
            r_rep <= r_rep + 1'b1;
        end
    end

    assign o_set = w_done | w_rep_wrap;
`else
    assign o_set = w_done;
`endif

    assign o_stable = r_stable;

endmodule
`default_nettype wire

// File: rtl/btn_debounce_irq.sv
`default_nettype none
// ============================================================================
//  Module   : btn_debounce_irq
//  Purpose  : Debounces the board buttons, keeps a sticky change mask, raises
//             irq towards the ESP32 and clears the reported bits once the
//             ESP32 finishes a chip-select-framed read of the snapshot byte.
//  Ports    : clk_25mhz  - system clock
//             resetn     - synchronous active-low reset
//             bus        - btn_debounce_irq_if.slave (btn_raw, csn in;
//                          btn_stable, btn_changed, snapshot, irq,
//                          read_done out)
//  Options  : BTN_AUTOREPEAT_EN - per-button auto-repeat of btn_changed
//  Revision : 1.0 - initial release
// ============================================================================
module btn_debounce_irq
    import ulx3s_btn_pkg::*;
#(
    parameter int                    C_BTN_BITS        = ulx3s_btn_pkg::C_BTN_BITS,
    parameter int                    C_SYNC_STAGES     = 2,
    parameter int                    C_DEBOUNCE_BITS   = 16,
`ifdef BTN_AUTOREPEAT_EN
    parameter int                    C_REPEAT_BITS     = 23,
`endif
    parameter logic [C_BTN_BITS-1:0] C_BTN_RESET_VALUE = ulx3s_btn_pkg::C_BTN_RESET_VALUE
) (
    input  wire logic         clk_25mhz,
    input  wire logic         resetn,
    btn_debounce_irq_if.slave bus
);

    localparam int C_IRQ_BIT = snap_irq_bit(C_BTN_BITS);

    logic [C_BTN_BITS-1:0]    w_stable;
    logic [C_BTN_BITS-1:0]    w_set;
    logic [C_BTN_BITS-1:0]    w_changed_next;
    logic [C_BTN_BITS-1:0]    r_changed;
    logic [C_BTN_BITS-1:0]    r_mask;
    logic [C_BTN_BITS:0]      r_snapshot;
    logic                     r_irq;
    logic                     r_read_done;
    logic [C_SYNC_STAGES-1:0] r_csn_sync;
    logic                     r_csn_prev;
    logic                     w_csn;
    logic                     w_csn_fall;
    logic                     w_csn_rise;
    logic                     w_capture;
    logic                     w_clear;
    read_state_t              r_state;
    read_state_t              w_state_next;

    for (genvar i = 0; i < C_BTN_BITS; i++) begin : g_cell
        btn_debounce_cell #(
            .C_SYNC_STAGES   (C_SYNC_STAGES),
            .C_DEBOUNCE_BITS (C_DEBOUNCE_BITS),
`ifdef BTN_AUTOREPEAT_EN
            .C_REPEAT_BITS   (C_REPEAT_BITS),
            .C_PRESSED_LEVEL ((i == 0) ? 1'b0 : 1'b1),
`endif
            .C_RESET_VALUE   (C_BTN_RESET_VALUE[i])
        ) u_cell (
            .clk      (clk_25mhz),
            .resetn   (resetn),
            .i_raw    (bus.btn_raw[i]),
            .o_stable (w_stable[i]),
            .o_set    (w_set[i])
        );
    end

    assign w_csn      = r_csn_sync[C_SYNC_STAGES-1];
    assign w_csn_fall =  r_csn_prev & ~w_csn;
    assign w_csn_rise = ~r_csn_prev &  w_csn;

    always_ff @(posedge clk_25mhz) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_csn_fall) begin
                    w_state_next = ST_SELECTED;
                    w_capture    = 1'b1;
                end
            end
            ST_SELECTED: begin
                if (w_csn_rise) begin
                    w_state_next = ST_IDLE;
                    w_clear      = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Clear only what the ESP32 was shown; a set in the same cycle wins.
    assign w_changed_next = (r_changed & ~(w_clear ? r_mask : '0)) | w_set;

    always_ff @(posedge clk_25mhz) begin
        if (!resetn) begin
            r_csn_sync  <= '1;
            r_csn_prev  <= 1'b1;
            r_changed   <= '0;
            r_mask      <= '0;
            r_irq       <= 1'b0;
            r_read_done <= 1'b0;
            r_snapshot  <= {1'b0, C_BTN_RESET_VALUE};
        end else begin
            r_csn_sync  <= {r_csn_sync[C_SYNC_STAGES-2:0], bus.csn};
            r_csn_prev  <= w_csn;
            r_changed   <= w_changed_next;
            r_irq       <= |w_changed_next;
            r_read_done <= w_clear;
            if (w_capture) begin
                r_mask <= r_changed;
            end
            // Tracking in IDLE also covers the capture edge, so the value
            // frozen for the read is the one current at the csn fall.
            if (r_state == ST_IDLE) begin
                r_snapshot[C_IRQ_BIT]       <= r_irq;
                r_snapshot[C_IRQ_BIT-1:0]   <= w_stable;
            end
        end
    end

    assign bus.btn_stable  = w_stable;
    assign bus.btn_changed = r_changed;
    assign bus.snapshot    = r_snapshot;
    assign bus.irq         = r_irq;
    assign bus.read_done   = r_read_done;

endmodule
`default_nettype wire
